alu_stage: RTL and testbench

Execute stage directly downstream of the barrel shifter. It consumes the shifted second operand and shifter carry-out, performs the ARM data-processing, load/store address or branch-target arithmetic, evaluates the condition field, and owns the NZCV status register. Its C flag feeds the shifter's carry-in. Results are registered behind a one-entry valid/ready output buffer that feeds writeback and memory.

---
 rtl/alu_stage.sv | 149 ++++++++++++++
 tb/tb_alu_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage.sv
// ARM execute stage: data-processing, load/store address and branch-target arithmetic,
// NZCV ownership and a one-entry output buffer. Condition evaluation is built only with ALU_STAGE_COND_EN.
module alu_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ir,
    input  logic [31:0] rn,
    input  logic [31:0] shifter_op,
    input  logic        shifter_c,
    output logic        c_flag,
    output logic [3:0]  flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  rd,
    output logic        wr_en,
    output logic        mem_en,
    output logic        branch_en
);
    logic [3:0]  nzcv;
    logic [3:0]  opc;
    logic        accept, cond_pass, is_dp, is_ls, is_br, is_test, is_logic, upd_flags;
    logic [31:0] add_a, add_b, logic_res, alu_res, next_res;
    logic        add_cin;
    logic [32:0] sum;
    logic [3:0]  next_nzcv;
    logic        unused_bits;

    assign opc      = ir[24:21];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign flags    = nzcv;
    assign c_flag   = nzcv[1];
    assign is_dp    = (ir[27:26] == 2'b00);
    assign is_ls    = (ir[27:26] == 2'b01);
    assign is_br    = (ir[27:25] == 3'b101);
    assign is_test  = (opc[3:2] == 2'b10);

`ifdef ALU_STAGE_COND_EN
    assign unused_bits = ^{ir[19:16], ir[11:0]};

    always_comb begin
        cond_pass = 1'b0;
        case (ir[31:28])
            4'h0: cond_pass = nzcv[2];
            4'h1: cond_pass = !nzcv[2];
            4'h2: cond_pass = nzcv[1];
            4'h3: cond_pass = !nzcv[1];
            4'h4: cond_pass = nzcv[3];
            4'h5: cond_pass = !nzcv[3];
            4'h6: cond_pass = nzcv[0];
            4'h7: cond_pass = !nzcv[0];
            4'h8: cond_pass = nzcv[1] && !nzcv[2];
            4'h9: cond_pass = !nzcv[1] || nzcv[2];
            4'hA: cond_pass = (nzcv[3] == nzcv[0]);
            4'hB: cond_pass = (nzcv[3] != nzcv[0]);
            4'hC: cond_pass = !nzcv[2] && (nzcv[3] == nzcv[0]);
            4'hD: cond_pass = nzcv[2] || (nzcv[3] != nzcv[0]);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`else
    assign unused_bits = ^{ir[31:28], ir[19:16], ir[11:0]};
    assign cond_pass   = 1'b1;
`endif

    always_comb begin
        is_logic = 1'b0;
        case (opc)
            4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF: is_logic = 1'b1;
            default: is_logic = 1'b0;
        endcase
    end

    // Every subtract goes through the single adder as a + ~b + cin.
    always_comb begin
        add_a   = rn;
        add_b   = shifter_op;
        add_cin = 1'b0;
        if (is_ls) begin
            add_b   = ir[23] ? shifter_op : ~shifter_op;
            add_cin = !ir[23];
        end else if (is_dp) begin
            case (opc)
                4'h2, 4'hA: begin add_b = ~shifter_op; add_cin = 1'b1; end
                4'h3:       begin add_a = ~rn; add_cin = 1'b1; end
                4'h5:       add_cin = nzcv[1];
                4'h6:       begin add_b = ~shifter_op; add_cin = nzcv[1]; end
                4'h7:       begin add_a = ~rn; add_cin = nzcv[1]; end
                default:    add_cin = 1'b0;
            endcase
        end
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    always_comb begin
        logic_res = rn & shifter_op;
        case (opc)
            4'h1, 4'h9: logic_res = rn ^ shifter_op;
            4'hC:       logic_res = rn | shifter_op;
            4'hD:       logic_res = shifter_op;
            4'hE:       logic_res = rn & ~shifter_op;
            4'hF:       logic_res = ~shifter_op;
            default:    logic_res = rn & shifter_op;
        endcase
    end

    assign alu_res  = is_logic ? logic_res : sum[31:0];
    assign next_res = is_dp ? alu_res : ((is_ls || is_br) ? sum[31:0] : 32'd0);

    assign next_nzcv[3] = alu_res[31];
    assign next_nzcv[2] = (alu_res == 32'd0);
    assign next_nzcv[1] = is_logic ? shifter_c : sum[32];
    assign next_nzcv[0] = is_logic ? nzcv[0]
                        : ((add_a[31] == add_b[31]) && (sum[31] != add_a[31]));

    assign upd_flags = accept && cond_pass && is_dp && (ir[20] || is_test);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nzcv <= 4'b0000;
        else if (upd_flags)
            nzcv <= next_nzcv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= 32'd0;
            rd        <= 4'd0;
            wr_en     <= 1'b0;
            mem_en    <= 1'b0;
            branch_en <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= next_res;
            rd        <= ir[15:12];
            wr_en     <= cond_pass && is_dp && !is_test;
            mem_en    <= cond_pass && is_ls;
            branch_en <= cond_pass && is_br;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_stage.sv
// Bench for alu_stage: directed scenarios then randomized traffic against a plain-arithmetic model.
// Honours ALU_STAGE_COND_EN the same way as the design.
module tb_alu_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] ir, rn, shifter_op;
    logic        shifter_c, c_flag;
    logic [3:0]  flags;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic [3:0]  rd;
    logic        wr_en, mem_en, branch_en;

    alu_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ir(ir), .rn(rn), .shifter_op(shifter_op), .shifter_c(shifter_c),
        .c_flag(c_flag), .flags(flags), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd(rd), .wr_en(wr_en), .mem_en(mem_en), .branch_en(branch_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        wr, mem, br, upd, rdef;
        logic [3:0]  nf;
    } beat_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic        m_valid;
    logic [3:0]  m_flags;
    beat_t       m_beat;
    logic [3:0]  m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cf;         4'h3: return !cf;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cf && !z;   4'h9: return !cf || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic beat_t ref_exec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                       input logic sc, input logic [3:0] f);
        beat_t r;
        logic [3:0] opc;
        logic [31:0] lr, p, q;
        logic lg, sub, cf, vf;
        longint ux, uy, sx, sy, u, s, k;
        r = '0;
        r.nf = f;
`ifdef ALU_STAGE_COND_EN
        if (!cond_ok(i[31:28], f)) return r;
`endif
        if (i[27:26] == 2'b00) begin
            opc = i[24:21];
            lg = 1'b1;
            lr = 32'd0;
            case (opc)
                4'd0, 4'd8: lr = a & b;
                4'd1, 4'd9: lr = a ^ b;
                4'd12:      lr = a | b;
                4'd13:      lr = b;
                4'd14:      lr = a & ~b;
                4'd15:      lr = ~b;
                default:    lg = 1'b0;
            endcase
            if (lg) begin
                r.res = lr;
                r.nf  = {lr[31], lr == 32'd0, sc, f[0]};
            end else begin
                p = a; q = b; sub = 1'b1; k = 1;
                case (opc)
                    4'd3:  begin p = b; q = a; end
                    4'd4:  begin sub = 1'b0; k = 0; end
                    4'd5:  begin sub = 1'b0; k = longint'(f[1]); end
                    4'd6:  k = longint'(f[1]);
                    4'd7:  begin p = b; q = a; k = longint'(f[1]); end
                    4'd11: begin sub = 1'b0; k = 0; end
                    default: k = 1;
                endcase
                ux = longint'(p);  uy = longint'(q);
                sx = $signed(p);   sy = $signed(q);
                if (sub) begin
                    u = ux - uy - (1 - k);
                    s = sx - sy - (1 - k);
                    cf = (u >= 0);
                end else begin
                    u = ux + uy + k;
                    s = sx + sy + k;
                    cf = (u >= 64'sh1_0000_0000);
                end
                vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                r.res = u[31:0];
                r.nf  = {u[31], u[31:0] == 32'd0, cf, vf};
            end
            r.wr   = !(opc inside {4'd8, 4'd9, 4'd10, 4'd11});
            r.upd  = i[20] || (opc inside {4'd8, 4'd9, 4'd10, 4'd11});
            r.rdef = 1'b1;
        end else if (i[27:26] == 2'b01) begin
            r.res  = i[23] ? a + b : a - b;
            r.mem  = 1'b1;
            r.rdef = 1'b1;
        end else if (i[27:25] == 3'b101) begin
            r.res  = a + b;
            r.br   = 1'b1;
            r.rdef = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] mk_dp(input logic [3:0] c, input logic [3:0] opc,
                                          input logic s, input logic [3:0] d);
        return {c, 3'b000, opc, s, 4'h0, d, 12'h000};
    endfunction

    task automatic compare_all();
        check("out_valid", out_valid, m_valid);
        check("in_ready", in_ready, !m_valid || out_ready);
        check("flags", flags, m_flags);
        check("c_flag", c_flag, m_flags[1]);
        if (m_valid) begin
            check("rd", rd, m_rd);
            check("wr_en", wr_en, m_beat.wr);
            check("mem_en", mem_en, m_beat.mem);
            check("branch_en", branch_en, m_beat.br);
            if (m_beat.rdef) check("result", result, m_beat.res);
        end
    endtask

    // Called just after a falling edge; covers the next rising edge and checks at the following fall.
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b, input logic sc, input logic ordy);
        in_valid = v; ir = i; rn = a; shifter_op = b; shifter_c = sc; out_ready = ordy;
        if (v && (!m_valid || ordy)) begin
            m_beat  = ref_exec(i, a, b, sc, m_flags);
            m_valid = 1'b1;
            m_rd    = i[15:12];
            if (m_beat.upd) m_flags = m_beat.nf;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        compare_all();
    endtask

    logic [31:0] r_ir, r_a, r_b;
    logic [2:0]  cls;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ir = '0; rn = '0; shifter_op = '0;
        shifter_c = 1'b0; out_ready = 1'b1;
        m_valid = 1'b0; m_flags = 4'b0000; m_beat = '0; m_rd = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_flags", flags, 4'b0000);
        check("rst_qual", {wr_en, mem_en, branch_en, rd}, 7'd0);
        rst_n = 1'b1;
        @(negedge clk);
        compare_all();

        step(1, mk_dp(4'hE, 4'h4, 1, 4'd3), 32'h7FFF_FFFF, 32'd1, 0, 1);
        check("adds_res", result, 32'h8000_0000);
        check("adds_nzcv", flags, 4'b1001);
        check("adds_wr_rd", {wr_en, rd}, {1'b1, 4'd3});

        step(1, mk_dp(4'hE, 4'h2, 1, 4'd4), 32'd5, 32'd5, 0, 1);
        check("subs_res", result, 32'd0);
        check("subs_nzcv", flags, 4'b0110);

        step(1, mk_dp(4'h0, 4'hD, 0, 4'd5), 32'd0, 32'h12, 0, 1);
        check("moveq_res", result, 32'h12);
        check("moveq_wr", wr_en, 1'b1);

        step(1, mk_dp(4'h1, 4'hD, 0, 4'd6), 32'd0, 32'h34, 0, 1);
`ifdef ALU_STAGE_COND_EN
        check("movne_wr", {out_valid, wr_en}, 2'b10);
`else
        check("movne_wr", {out_valid, wr_en, result}, {2'b11, 32'h34});
`endif
        check("movne_flags", flags, 4'b0110);

        step(1, mk_dp(4'hE, 4'h0, 1, 4'd7), 32'hF0, 32'h0F, 1, 1);
        check("ands_res", result, 32'd0);
        check("ands_nzcv", flags, 4'b0110);
        check("ands_cflag", c_flag, 1'b1);

        step(1, {4'hE, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h6, 12'h004}, 32'h100, 32'd4, 0, 1);
        check("ldr_res", result, 32'hFC);
        check("ldr_mem", {mem_en, wr_en, branch_en}, 3'b100);
        check("ldr_flags", flags, 4'b0110);

        step(1, {4'hE, 3'b101, 25'd0}, 32'h1000, 32'hFFFF_FFF8, 0, 1);
        check("b_res", result, 32'hFF8);
        check("b_qual", {branch_en, wr_en, mem_en}, 3'b100);

        step(1, mk_dp(4'hE, 4'h4, 1, 4'd8), 32'd1, 32'd1, 0, 1);
        check("pre_stall_flags", flags, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            step(1, mk_dp(4'hE, 4'h2, 1, 4'd9), 32'd5, 32'd5, 0, 0);
            check("stall_hold", {out_valid, in_ready, result, rd}, {2'b10, 32'd2, 4'd8});
            check("stall_flags", flags, 4'b0000);
        end
        step(1, mk_dp(4'hE, 4'h2, 1, 4'd9), 32'd5, 32'd5, 0, 1);
        check("post_stall", {result, rd, flags}, {32'd0, 4'd9, 4'b0110});

        step(1, mk_dp(4'hE, 4'h4, 1, 4'd1), 32'hFFFF_FFFF, 32'd1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_flags", flags, 4'b0000);
        m_valid = 1'b0; m_flags = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 check("post_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        compare_all();

        for (int n = 0; n < 800; n++) begin
            cls  = 3'($urandom_range(0, 7));
            r_ir = $urandom;
            r_ir[27:25] = cls;
            if ($urandom_range(0, 3) == 0) r_ir[31:28] = 4'hE;
            r_a = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = r_a;
                1: r_b = 32'd0;
                2: r_b = 32'h8000_0000;
                3: r_b = 32'h7FFF_FFFF;
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) r_a = 32'hFFFF_FFFF;
            step($urandom_range(0, 3) != 0, r_ir, r_a, r_b, 1'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
